// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the LSU memory master.
// Size encodings, FSM state enum and lane shift/mask helpers.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B   = 2'b00,
      SZ_H   = 2'b01,
      SZ_W   = 2'b10,
      SZ_RSV = 2'b11
   } size_e;

   typedef enum logic [2:0] {
      StIdle,
      StErr,
      StRd,
      StRdWt,
      StWr,
      StRmwRd,
      StRmwWt,
      StResp
   } state_e;

   localparam logic [31:0] BYTE_MASK = 32'h0000_00ff;
   localparam logic [31:0] HALF_MASK = 32'h0000_ffff;

   // Bit offset of the addressed lane inside the word (little-endian).
   function automatic logic [4:0] lane_shift(input logic [1:0] addr_lo, input size_e size);
      case (size)
         SZ_B:    return {addr_lo, 3'b000};
         SZ_H:    return {addr_lo[1], 4'b0000};
         default: return 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: load extract/extend and sub-word store merge.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  size_e       size_i,
   input  logic        unsigned_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

   logic [4:0]  shift;
   logic [31:0] lane;
   logic [31:0] mask;

   always_comb begin
      shift = lane_shift(addr_lo_i, size_i);
      lane  = rdata_i >> shift;
      case (size_i)
         SZ_B: begin
            mask   = BYTE_MASK;
            load_o = unsigned_i ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
         end
         SZ_H: begin
            mask   = HALF_MASK;
            load_o = unsigned_i ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
         end
         default: begin
            mask   = 32'hffff_ffff;
            load_o = lane;
         end
      endcase
      // Only the addressed lane is replaced; the other bytes come from the read word.
      merge_o = (rdata_i & ~(mask << shift)) | ((wdata_i & mask) << shift);
   end

endmodule

// File: rtl/lsu_mem_master.sv
// MEM-stage load/store initiator for a word-indexed memory with 1-cycle registered reads.
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 32,
   parameter int unsigned IDX_W     = 5
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   output logic        rsp_err_o,
   output logic [31:0] rsp_rdata_o,
   output logic        mem_write_o,
   output logic        mem_read_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

   state_e      state_q, state_d;
   size_e       size_q, size_d;
   logic        uns_q, uns_d;
   logic [1:0]  addr_lo_q, addr_lo_d;
   logic [31:0] wdata_q, wdata_d;

   logic        ready_q, ready_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        mem_write_q, mem_write_d;
   logic        mem_read_q, mem_read_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;

   logic [31:0] load_data;
   logic [31:0] merge_data;
   logic        req_err;
   size_e       req_size;

   lsu_lane_align u_lane_align (
      .addr_lo_i  (addr_lo_q),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .rdata_i    (mem_rdata_i),
      .wdata_i    (wdata_q),
      .load_o     (load_data),
      .merge_o    (merge_data)
   );

   always_comb begin
      req_size = size_e'(req_size_i);
      req_err  = (req_size == SZ_RSV)
               | ((req_size == SZ_H) & req_addr_i[0])
               | ((req_size == SZ_W) & (req_addr_i[1:0] != 2'b00))
               | (req_addr_i[31:2] >= 30'(MEM_WORDS));
   end

   always_comb begin
      state_d     = state_q;
      size_d      = size_q;
      uns_d       = uns_q;
      addr_lo_d   = addr_lo_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = 32'h0;
      mem_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      // Outputs are computed for the state being entered, so they line up with state_q.
      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               size_d    = req_size;
               uns_d     = req_unsigned_i;
               addr_lo_d = req_addr_i[1:0];
               wdata_d   = req_wdata_i;
               if (req_err) begin
                  state_d     = StErr;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
               end else begin
                  mem_addr_d = {{(32 - IDX_W){1'b0}}, req_addr_i[IDX_W+1:2]};
                  if (!req_we_i) begin
                     state_d    = StRd;
                     mem_read_d = 1'b1;
                  end else if (req_size == SZ_W) begin
                     state_d     = StWr;
                     mem_write_d = 1'b1;
                     mem_wdata_d = req_wdata_i;
                  end else begin
                     state_d    = StRmwRd;
                     mem_read_d = 1'b1;
                  end
               end
            end
         end
         StErr:   state_d = StIdle;
         StRd:    state_d = StRdWt;
         StRdWt: begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = load_data;
         end
         StWr: begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
         end
         StRmwRd: state_d = StRmwWt;
         StRmwWt: begin
            state_d     = StWr;
            mem_write_d = 1'b1;
            mem_wdata_d = merge_data;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      ready_d = (state_d == StIdle);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q     <= StIdle;
         size_q      <= SZ_B;
         uns_q       <= 1'b0;
         addr_lo_q   <= 2'b00;
         wdata_q     <= 32'h0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'h0;
         mem_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         addr_lo_q   <= addr_lo_d;
         wdata_q     <= wdata_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         mem_write_q <= mem_write_d;
         mem_read_q  <= mem_read_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign req_ready_o = ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign mem_write_o = mem_write_q;
   assign mem_read_o  = mem_read_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a behavioural 32-word registered-read memory.
module tb_lsu_mem_master;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_err;
   logic [31:0] rsp_rdata;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [32];
   logic        mem_init;

   int n_cmp;
   int n_bad;

   int overlap_cnt;
   int long_strobe_cnt;
   int wr_cnt;
   int rsp_cnt;
   logic prev_rd;
   logic prev_wr;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic        err;
      logic [31:0] rdata;
      int          nrd;
      int          nwr;
   } vec_t;

   vec_t vecs[20];

   lsu_mem_master #(
      .MEM_WORDS (32),
      .IDX_W     (5)
   ) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_we_i       (req_we),
      .req_size_i     (req_size),
      .req_unsigned_i (req_unsigned),
      .req_addr_i     (req_addr),
      .req_wdata_i    (req_wdata),
      .rsp_valid_o    (rsp_valid),
      .rsp_err_o      (rsp_err),
      .rsp_rdata_o    (rsp_rdata),
      .mem_write_o    (mem_write),
      .mem_read_o     (mem_read),
      .mem_addr_o     (mem_addr),
      .mem_wdata_o    (mem_wdata),
      .mem_rdata_i    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
         mem[4]    <= 32'h1122_3344;
         mem[6]    <= 32'h0102_0304;
         mem_rdata <= 32'h0;
      end else begin
         if (mem_write) mem[mem_addr[4:0]] <= mem_wdata;
         if (mem_read) mem_rdata <= mem[mem_addr[4:0]];
      end
   end

   always @(negedge clk) begin
      if (mem_read && mem_write) overlap_cnt <= overlap_cnt + 1;
      if ((mem_read && prev_rd) || (mem_write && prev_wr)) long_strobe_cnt <= long_strobe_cnt + 1;
      if (mem_write) wr_cnt <= wr_cnt + 1;
      if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
      prev_rd <= mem_read;
      prev_wr <= mem_write;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_req(input vec_t v, output int lat, output logic err,
                          output logic [31:0] rdata, output int nrd, output int nwr);
      int guard;
      lat   = -1;
      err   = 1'b0;
      rdata = 32'h0;
      nrd   = 0;
      nwr   = 0;
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = v.we;
      req_size     = v.size;
      req_unsigned = v.uns;
      req_addr     = v.addr;
      req_wdata    = v.wdata;
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         if (mem_read) nrd++;
         if (mem_write) nwr++;
         if (rsp_valid) begin
            lat   = n;
            err   = rsp_err;
            rdata = rsp_rdata;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int          lat;
      logic        err;
      logic [31:0] rdata;
      int          nrd;
      int          nwr;
      int          acc;
      int          rsp0;
      int          wr0;

      n_cmp = 0;
      n_bad = 0;
      overlap_cnt = 0;
      long_strobe_cnt = 0;
      wr_cnt = 0;
      rsp_cnt = 0;
      prev_rd = 1'b0;
      prev_wr = 1'b0;
      rst_n = 1'b0;
      mem_init = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_size = 2'b00;
      req_unsigned = 1'b0;
      req_addr = 32'h0;
      req_wdata = 32'h0;

      //         we    size   uns   addr       wdata         lat err   rdata          rd wr
      vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 2, 1'b0, 32'h00000000, 0, 1};
      vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h08, 32'h0,        3, 1'b0, 32'hDEADBEEF, 1, 0};
      vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, 4, 1'b0, 32'h00000000, 1, 1};
      vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h12, 32'h0,        3, 1'b0, 32'hFFFFFFAA, 1, 0};
      vecs[4]  = '{1'b0, 2'b00, 1'b1, 32'h12, 32'h0,        3, 1'b0, 32'h000000AA, 1, 0};
      vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        3, 1'b0, 32'h11AA3344, 1, 0};
      vecs[6]  = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        3, 1'b0, 32'h00000011, 1, 0};
      vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        3, 1'b0, 32'h00003344, 1, 0};
      vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h16, 32'h00008001, 4, 1'b0, 32'h00000000, 1, 1};
      vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h16, 32'h0,        3, 1'b0, 32'hFFFF8001, 1, 0};
      vecs[10] = '{1'b0, 2'b01, 1'b1, 32'h16, 32'h0,        3, 1'b0, 32'h00008001, 1, 0};
      vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h14, 32'h0,        3, 1'b0, 32'h80010000, 1, 0};
      vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h06, 32'h0,        1, 1'b1, 32'h00000000, 0, 0};
      vecs[13] = '{1'b0, 2'b01, 1'b0, 32'h05, 32'h0,        1, 1'b1, 32'h00000000, 0, 0};
      vecs[14] = '{1'b0, 2'b10, 1'b0, 32'h80, 32'h0,        1, 1'b1, 32'h00000000, 0, 0};
      vecs[15] = '{1'b0, 2'b11, 1'b0, 32'h00, 32'h0,        1, 1'b1, 32'h00000000, 0, 0};
      vecs[16] = '{1'b1, 2'b10, 1'b0, 32'h02, 32'hFFFFFFFF, 1, 1'b1, 32'h00000000, 0, 0};
      vecs[17] = '{1'b1, 2'b10, 1'b0, 32'h7C, 32'h12345678, 2, 1'b0, 32'h00000000, 0, 1};
      vecs[18] = '{1'b0, 2'b10, 1'b0, 32'h7C, 32'h0,        3, 1'b0, 32'h12345678, 1, 0};
      vecs[19] = '{1'b0, 2'b10, 1'b0, 32'h00, 32'h0,        3, 1'b0, 32'h00000000, 1, 0};

      repeat (3) @(negedge clk);
      chk("rst rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst rsp_err", {31'h0, rsp_err}, 32'h0);
      chk("rst rsp_rdata", rsp_rdata, 32'h0);
      chk("rst mem_read", {31'h0, mem_read}, 32'h0);
      chk("rst mem_write", {31'h0, mem_write}, 32'h0);
      chk("rst mem_addr", mem_addr, 32'h0);
      chk("rst mem_wdata", mem_wdata, 32'h0);
      rst_n = 1'b1;
      mem_init = 1'b0;
      @(negedge clk);
      chk("rst ready", {31'h0, req_ready}, 32'h1);

      for (int i = 0; i < 20; i++) begin
         run_req(vecs[i], lat, err, rdata, nrd, nwr);
         chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
         chk($sformatf("v%0d err", i), {31'h0, err}, {31'h0, vecs[i].err});
         chk($sformatf("v%0d rdata", i), rdata, vecs[i].rdata);
         chk($sformatf("v%0d reads", i), nrd, vecs[i].nrd);
         chk($sformatf("v%0d writes", i), nwr, vecs[i].nwr);
         if (i == 2) chk("sb merged word", mem[4], 32'h11AA3344);
      end
      chk("sw word 31", mem[31], 32'h12345678);

      // Reset during RMW_WT of a half store: no write, no response.
      @(negedge clk);
      req_valid = 1'b1;
      req_we = 1'b1;
      req_size = 2'b01;
      req_unsigned = 1'b0;
      req_addr = 32'h1A;
      req_wdata = 32'h0000BEEF;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("rmw rd strobe", {31'h0, mem_read}, 32'h1);
      #1;
      wr0 = wr_cnt;
      rsp0 = rsp_cnt;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      chk("rst mid wr", wr_cnt, wr0);
      chk("rst mid rsp", rsp_cnt, rsp0);
      chk("rst mid mem", mem[6], 32'h01020304);
      chk("rst mid ready", {31'h0, req_ready}, 32'h1);

      // Back-to-back loads with valid held: accept every 4 cycles.
      @(negedge clk);
      req_valid = 1'b1;
      req_we = 1'b0;
      req_size = 2'b10;
      req_addr = 32'h08;
      #1;
      rsp0 = rsp_cnt;
      acc = 0;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) @(negedge clk);
         chk($sformatf("b2b ready c%0d", i), {31'h0, req_ready}, {31'h0, (i % 4) == 0});
         if (req_ready) acc++;
      end
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("b2b accepts", acc, 3);
      chk("b2b responses", rsp_cnt - rsp0, 3);
      chk("strobe overlap", overlap_cnt, 0);
      chk("strobe length", long_strobe_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
